// File: rtl/trap_pkg.sv
// trap_pkg: shared types and constants for the machine-mode trap sequencer.
//   trap_state_e : sequencer states (RUN -> FLUSH -> REDIRECT -> RUN)
//   CAUSE_*      : synchronous exception cause codes written to mcause
//   csr_sel_e    : CSR write-port select codes
//   IRQ_CAUSE_BASE : interrupt i reports cause IRQ_CAUSE_BASE + i
package trap_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2
  } trap_state_e;

  localparam logic [4:0] CAUSE_INSTR_MISALIGN = 5'd0;
  localparam logic [4:0] CAUSE_ILLEGAL        = 5'd2;
  localparam logic [4:0] CAUSE_LOAD_MISALIGN  = 5'd4;
  localparam logic [4:0] CAUSE_STORE_MISALIGN = 5'd6;

  typedef enum logic [1:0] {
    CSR_MTVEC   = 2'd0,
    CSR_MIE     = 2'd1,
    CSR_MSTATUS = 2'd2
  } csr_sel_e;

  localparam int unsigned IRQ_CAUSE_BASE = 16;

  // Misalignment of a load/store: byte never, half on odd address,
  // word on any non-multiple of four. Size 3 is handled as illegal elsewhere.
  function automatic logic ls_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (size)
      2'd1:    mis = addr_lo[0];
      2'd2:    mis = (addr_lo != 2'd0);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/trap_prio_enc.sv
// trap_prio_enc: lowest-index-wins priority encoder.
//   req_i   : request vector (irq & mie)
//   valid_o : at least one request set
//   idx_o   : index of the lowest set request (0 when none)
module trap_prio_enc #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  always_comb begin
    valid_o = |req_i;
    idx_o   = '0;
    // Walk from the top down so the lowest set index is the last assignment.
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/trap_controller.sv
// trap_controller: machine-mode trap sequencer for the single-cycle core.
// Detects synchronous exceptions, masked interrupts and mret on the
// instruction in execute, kills it, updates the trap CSRs, and runs a
// FLUSH -> REDIRECT sequence toward the handler or the return address.
//   Inputs : instr_valid/instr/pc, opinvalid, jump_req/jump_target,
//            ls_req/ls_store/ls_size/ls_addr, mret, irq, csr_we/csr_sel/csr_wdata
//   Outputs: kill (combinational), stall/flush/pc_redirect/redirect_pc
//            (registered), mepc/mcause/mtval, in_handler
module trap_controller
  import trap_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              NUM_IRQ   = 4,
  parameter int              VECTORED  = 1,
  parameter logic [XLEN-1:0] TRAP_BASE = 32'h0000_0100
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  input  logic [31:0]        instr,
  input  logic [XLEN-1:0]    pc,
  input  logic               opinvalid,
  input  logic               jump_req,
  input  logic [XLEN-1:0]    jump_target,
  input  logic               ls_req,
  input  logic               ls_store,
  input  logic [1:0]         ls_size,
  input  logic [XLEN-1:0]    ls_addr,
  input  logic               mret,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               csr_we,
  input  logic [1:0]         csr_sel,
  input  logic [XLEN-1:0]    csr_wdata,
  output logic               kill,
  output logic               stall,
  output logic               flush,
  output logic               pc_redirect,
  output logic [XLEN-1:0]    redirect_pc,
  output logic [XLEN-1:0]    mepc,
  output logic [XLEN-1:0]    mcause,
  output logic [XLEN-1:0]    mtval,
  output logic               in_handler
);

  localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  trap_state_e          state_q;
  logic                 stall_q, flush_q, pc_redirect_q, in_handler_q;
  logic [XLEN-1:0]      redirect_q, mepc_q, mcause_q, mtval_q, mtvec_q;
  logic [NUM_IRQ-1:0]   mie_q;
  logic                 mstatus_mie_q, mpie_q;

  logic                 irq_vld;
  logic [IDX_W-1:0]     irq_idx;

  trap_prio_enc #(.N(NUM_IRQ), .IDX_W(IDX_W)) u_prio (
    .req_i   (irq & mie_q),
    .valid_o (irq_vld),
    .idx_o   (irq_idx)
  );

  logic            in_run, illegal, jmp_mis, ls_mis;
  logic            sync_take, irq_take, mret_take;
  logic [4:0]      exc_cause;
  logic [XLEN-1:0] exc_tval, irq_cause, irq_target;

  always_comb begin
    in_run    = (state_q == RUN);
    illegal   = opinvalid || (ls_req && (ls_size == 2'd3));
    jmp_mis   = jump_req && (jump_target[1:0] != 2'd0);
    ls_mis    = ls_req && ls_misaligned(ls_size, ls_addr[1:0]);
    sync_take = in_run && instr_valid && (illegal || jmp_mis || ls_mis);
    irq_take  = in_run && instr_valid && !sync_take && mstatus_mie_q && irq_vld;
    mret_take = in_run && instr_valid && mret && !sync_take && !irq_take;

    if (illegal) begin
      exc_cause = CAUSE_ILLEGAL;
      exc_tval  = XLEN'(instr);
    end else if (jmp_mis) begin
      exc_cause = CAUSE_INSTR_MISALIGN;
      exc_tval  = jump_target;
    end else begin
      exc_cause = ls_store ? CAUSE_STORE_MISALIGN : CAUSE_LOAD_MISALIGN;
      exc_tval  = ls_addr;
    end

    irq_cause  = XLEN'(IRQ_CAUSE_BASE) + XLEN'(irq_idx);
    irq_target = (VECTORED != 0) ? (mtvec_q + (irq_cause << 2)) : mtvec_q;
  end

  assign kill = sync_take || irq_take || mret_take;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= RUN;
      stall_q       <= 1'b0;
      flush_q       <= 1'b0;
      pc_redirect_q <= 1'b0;
      in_handler_q  <= 1'b0;
      redirect_q    <= '0;
      mepc_q        <= '0;
      mcause_q      <= '0;
      mtval_q       <= '0;
      mtvec_q       <= TRAP_BASE;
      mie_q         <= '0;
      mstatus_mie_q <= 1'b0;
      mpie_q        <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (sync_take || irq_take) begin
            mepc_q        <= pc;
            mcause_q      <= sync_take ? XLEN'(exc_cause)
                                       : {1'b1, irq_cause[XLEN-2:0]};
            mtval_q       <= sync_take ? exc_tval : '0;
            redirect_q    <= sync_take ? mtvec_q : irq_target;
            mpie_q        <= mstatus_mie_q;
            mstatus_mie_q <= 1'b0;
            in_handler_q  <= 1'b1;
            state_q       <= FLUSH;
            stall_q       <= 1'b1;
            flush_q       <= 1'b1;
          end else if (mret_take) begin
            redirect_q    <= mepc_q;
            mstatus_mie_q <= mpie_q;
            mpie_q        <= 1'b1;
            in_handler_q  <= 1'b0;
            state_q       <= FLUSH;
            stall_q       <= 1'b1;
            flush_q       <= 1'b1;
          end else if (csr_we) begin
            // Only reached when nothing is killed, so kill-cycle writes drop.
            case (csr_sel_e'(csr_sel))
              CSR_MTVEC:   mtvec_q       <= {csr_wdata[XLEN-1:2], 2'b00};
              CSR_MIE:     mie_q         <= csr_wdata[NUM_IRQ-1:0];
              CSR_MSTATUS: mstatus_mie_q <= csr_wdata[0];
              default:     ;
            endcase
          end
        end
        FLUSH: begin
          state_q       <= REDIRECT;
          flush_q       <= 1'b0;
          pc_redirect_q <= 1'b1;
        end
        REDIRECT: begin
          state_q       <= RUN;
          stall_q       <= 1'b0;
          pc_redirect_q <= 1'b0;
        end
        default: begin
          state_q       <= RUN;
          stall_q       <= 1'b0;
          flush_q       <= 1'b0;
          pc_redirect_q <= 1'b0;
        end
      endcase
    end
  end

  assign stall       = stall_q;
  assign flush       = flush_q;
  assign pc_redirect = pc_redirect_q;
  assign redirect_pc = redirect_q;
  assign mepc        = mepc_q;
  assign mcause      = mcause_q;
  assign mtval       = mtval_q;
  assign in_handler  = in_handler_q;

endmodule

// File: tb/tb_trap_controller.sv
module tb_trap_controller;

  localparam int XLEN = 32;
  localparam int NIRQ = 4;
  localparam int VEC  = 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             instr_valid;
  logic [31:0]      instr;
  logic [31:0]      pc;
  logic             opinvalid;
  logic             jump_req;
  logic [31:0]      jump_target;
  logic             ls_req;
  logic             ls_store;
  logic [1:0]       ls_size;
  logic [31:0]      ls_addr;
  logic             mret;
  logic [NIRQ-1:0]  irq;
  logic             csr_we;
  logic [1:0]       csr_sel;
  logic [31:0]      csr_wdata;
  logic             kill, stall, flush, pc_redirect, in_handler;
  logic [31:0]      redirect_pc, mepc, mcause, mtval;

  int checks   = 0;
  int failures = 0;

  trap_controller #(.XLEN(XLEN), .NUM_IRQ(NIRQ), .VECTORED(VEC),
                    .TRAP_BASE(32'h0000_0100)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .pc(pc), .opinvalid(opinvalid), .jump_req(jump_req),
    .jump_target(jump_target), .ls_req(ls_req), .ls_store(ls_store),
    .ls_size(ls_size), .ls_addr(ls_addr), .mret(mret), .irq(irq),
    .csr_we(csr_we), .csr_sel(csr_sel), .csr_wdata(csr_wdata),
    .kill(kill), .stall(stall), .flush(flush), .pc_redirect(pc_redirect),
    .redirect_pc(redirect_pc), .mepc(mepc), .mcause(mcause), .mtval(mtval),
    .in_handler(in_handler)
  );

  always #5 clk = ~clk;

  // Reference model: architectural state plus a phase number
  // (0 = accepting instructions, 1 = flushing, 2 = redirecting).
  bit [31:0] m_mepc, m_mcause, m_mtval, m_mtvec, m_redir;
  bit [3:0]  m_mie;
  bit        m_MIE, m_MPIE, m_inh;
  int        m_phase;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  // Classifies the current inputs: 0 none, 1 exception, 2 interrupt, 3 mret.
  function automatic int model_kind(output bit [31:0] cause, output bit [31:0] tval,
                                    output bit [31:0] tgt);
    bit ill, jmis, lmis;
    int sz;
    cause = 0; tval = 0; tgt = 0;
    if (m_phase != 0 || !instr_valid) return 0;
    ill  = opinvalid || (ls_req && ls_size == 2'd3);
    jmis = jump_req && (jump_target % 4 != 0);
    sz   = 1 << ls_size;
    lmis = ls_req && ls_size != 2'd3 && (ls_addr % sz != 0);
    if (ill)  begin cause = 2; tval = instr;       tgt = m_mtvec; return 1; end
    if (jmis) begin cause = 0; tval = jump_target; tgt = m_mtvec; return 1; end
    if (lmis) begin cause = ls_store ? 6 : 4; tval = ls_addr; tgt = m_mtvec; return 1; end
    if (m_MIE) begin
      for (int i = 0; i < NIRQ; i++) begin
        if (irq[i] && m_mie[i]) begin
          cause = 32'h8000_0000 | (16 + i);
          tgt   = VEC ? m_mtvec + 4 * (16 + i) : m_mtvec;
          return 2;
        end
      end
    end
    if (mret) begin tgt = m_mepc; return 3; end
    return 0;
  endfunction

  task automatic model_edge();
    bit [31:0] c, t, g;
    int k;
    if (!rst_n) begin
      m_mepc = 0; m_mcause = 0; m_mtval = 0; m_mtvec = 32'h100; m_redir = 0;
      m_mie = 0; m_MIE = 0; m_MPIE = 0; m_inh = 0; m_phase = 0;
    end else if (m_phase == 1) m_phase = 2;
    else if (m_phase == 2) m_phase = 0;
    else begin
      k = model_kind(c, t, g);
      if (k == 1 || k == 2) begin
        m_mepc = pc; m_mcause = c; m_mtval = t; m_redir = g;
        m_MPIE = m_MIE; m_MIE = 0; m_inh = 1; m_phase = 1;
      end else if (k == 3) begin
        m_redir = g; m_MIE = m_MPIE; m_MPIE = 1; m_inh = 0; m_phase = 1;
      end else if (csr_we) begin
        case (csr_sel)
          2'd0: m_mtvec = csr_wdata & ~32'h3;
          2'd1: m_mie   = csr_wdata[3:0];
          2'd2: m_MIE   = csr_wdata[0];
          default: ;
        endcase
      end
    end
  endtask

  // One clock: check kill on the settled inputs, clock, then check registers.
  task automatic step();
    bit [31:0] c, t, g;
    int k;
    #1;
    k = model_kind(c, t, g);
    if (rst_n) chk("kill", {31'b0, kill}, {31'b0, k != 0});
    @(posedge clk);
    model_edge();
    #1;
    chk("stall",       {31'b0, stall},       {31'b0, m_phase != 0});
    chk("flush",       {31'b0, flush},       {31'b0, m_phase == 1});
    chk("pc_redirect", {31'b0, pc_redirect}, {31'b0, m_phase == 2});
    chk("redirect_pc", redirect_pc, m_redir);
    chk("mepc",        mepc,   m_mepc);
    chk("mcause",      mcause, m_mcause);
    chk("mtval",       mtval,  m_mtval);
    chk("in_handler",  {31'b0, in_handler}, {31'b0, m_inh});
  endtask

  task automatic idle();
    instr_valid = 0; instr = 0; pc = 0; opinvalid = 0; jump_req = 0;
    jump_target = 0; ls_req = 0; ls_store = 0; ls_size = 0; ls_addr = 0;
    mret = 0; irq = 0; csr_we = 0; csr_sel = 0; csr_wdata = 0;
  endtask

  task automatic finish_seq();
    idle(); step(); step();
  endtask

  task automatic do_illegal(input logic [31:0] p);
    idle(); instr_valid = 1; opinvalid = 1; pc = p; instr = 32'hDEAD_BEEF; step();
  endtask

  task automatic do_mret();
    idle(); instr_valid = 1; mret = 1; step(); finish_seq();
  endtask

  task automatic csr_write(input logic [1:0] sel, input logic [31:0] d);
    idle(); csr_we = 1; csr_sel = sel; csr_wdata = d; step();
  endtask

  task automatic rnd_inputs();
    instr_valid = ($urandom_range(0, 3) != 0);
    instr       = $urandom;
    pc          = $urandom & ~32'h3;
    opinvalid   = ($urandom_range(0, 15) == 0);
    jump_req    = ($urandom_range(0, 3) == 0);
    jump_target = {$urandom_range(0, 255), 22'b0, 2'($urandom_range(0, 3))} |
                  (($urandom_range(0, 1) != 0) ? 32'h0 : 32'h0);
    if ($urandom_range(0, 1) != 0) jump_target[1:0] = 2'b00;
    ls_req      = ($urandom_range(0, 2) == 0);
    ls_store    = $urandom_range(0, 1) != 0;
    ls_size     = 2'($urandom_range(0, 3));
    ls_addr     = $urandom;
    mret        = ($urandom_range(0, 15) == 0);
    irq         = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
    csr_we      = ($urandom_range(0, 7) == 0);
    csr_sel     = 2'($urandom_range(0, 3));
    csr_wdata   = $urandom;
  endtask

  initial begin
    idle();
    rst_n = 0;
    step(); step();
    chk("reset_mepc",   mepc, 32'h0);
    chk("reset_redir",  redirect_pc, 32'h0);
    chk("reset_stall",  {31'b0, stall}, 32'h0);
    rst_n = 1;

    // Illegal opcode with all-ones instruction word.
    idle(); instr_valid = 1; opinvalid = 1; pc = 32'h40; instr = 32'hFFFF_FFFF;
    #1 chk("t1_kill", {31'b0, kill}, 32'h1);
    step();
    chk("t1_mepc", mepc, 32'h40);
    chk("t1_mcause", mcause, 32'h2);
    chk("t1_mtval", mtval, 32'hFFFF_FFFF);
    idle(); step();
    chk("t1_pcr", {31'b0, pc_redirect}, 32'h1);
    chk("t1_redir", redirect_pc, 32'h100);
    step();
    do_mret();
    chk("t1_mret_redir", redirect_pc, 32'h40);
    chk("t1_mret_inh", {31'b0, in_handler}, 32'h0);

    // Misaligned word load, then a byte store that must not trap.
    idle(); instr_valid = 1; ls_req = 1; ls_size = 2; ls_addr = 32'h1002; pc = 32'h44;
    step();
    chk("t2_mcause", mcause, 32'h4);
    chk("t2_mtval", mtval, 32'h1002);
    finish_seq(); do_mret();
    idle(); instr_valid = 1; ls_req = 1; ls_store = 1; ls_size = 0; ls_addr = 32'h1003;
    #1 chk("t2_byte_kill", {31'b0, kill}, 32'h0);
    step();

    // Enable irq1/irq2 and MIE; illegal + misaligned jump reports illegal only.
    csr_write(2'd1, 32'h6);
    csr_write(2'd2, 32'h1);
    idle(); instr_valid = 1; opinvalid = 1; jump_req = 1; jump_target = 32'h202;
    pc = 32'h60; instr = 32'h1234_5678; step();
    chk("t3_mcause", mcause, 32'h2);
    chk("t3_mtval", mtval, 32'h1234_5678);
    finish_seq();
    do_mret();
    chk("t3_mret_redir", redirect_pc, 32'h60);

    // Vectored interrupt: MIE restored by mret lets irq1 in.
    idle(); instr_valid = 1; irq = 4'b1110; pc = 32'h80; step();
    chk("t4_mcause", mcause, 32'h8000_0011);
    chk("t4_mepc", mepc, 32'h80);
    idle(); step();
    chk("t4_redir", redirect_pc, 32'h144);
    step();
    // Now MIE=0 inside the handler: same stimulus must not trap.
    idle(); instr_valid = 1; irq = 4'b1110; pc = 32'h144;
    #1 chk("t4_mie0_kill", {31'b0, kill}, 32'h0);
    step();
    do_mret();

    // mtvec low bits forced to zero; write during a kill cycle is dropped.
    csr_write(2'd0, 32'h203);
    do_illegal(32'h90); finish_seq();
    chk("t5_mtvec", redirect_pc, 32'h200);
    do_mret();
    idle(); instr_valid = 1; opinvalid = 1; pc = 32'h94; csr_we = 1; csr_sel = 0;
    csr_wdata = 32'h300; step(); finish_seq(); do_mret();
    do_illegal(32'h98); finish_seq();
    chk("t5_kill_write", redirect_pc, 32'h200);
    do_mret();

    // Reset during FLUSH aborts the sequence.
    do_illegal(32'hA0);
    idle(); rst_n = 0; step();
    chk("t6_pcr", {31'b0, pc_redirect}, 32'h0);
    chk("t6_mcause", mcause, 32'h0);
    rst_n = 1;
    step();
    chk("t6_pcr2", {31'b0, pc_redirect}, 32'h0);

    // Randomized traffic against the model, with occasional resets.
    for (int n = 0; n < 4000; n++) begin
      rnd_inputs();
      rst_n = ($urandom_range(0, 199) != 0);
      step();
    end
    rst_n = 1;
    idle(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
